// File: rtl/rv_controller.sv
// flintRV main decoder: major opcode to registered control bundle.
// Bundle is {aluOp, exec_a, exec_b, mem_w, reg_w, mem2reg, bra, jmp}.
module rv_controller (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    output logic [3:0] aluOp,
    output logic       exec_a,
    output logic       exec_b,
    output logic       mem_w,
    output logic       reg_w,
    output logic       mem2reg,
    output logic       bra,
    output logic       jmp
);

    localparam logic [6:0] OP_R       = 7'b0110011;
    localparam logic [6:0] OP_I_ARITH = 7'b0010011;
    localparam logic [6:0] OP_I_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_I_JALR  = 7'b1100111;
    localparam logic [6:0] OP_S       = 7'b0100011;
    localparam logic [6:0] OP_B       = 7'b1100011;
    localparam logic [6:0] OP_LUI     = 7'b0110111;
    localparam logic [6:0] OP_AUIPC   = 7'b0010111;
    localparam logic [6:0] OP_JAL     = 7'b1101111;

    logic [12:0] w_dec;
    logic [12:0] r_bundle;

    // SYSTEM, FENCE and every unknown code fall through to a NOP bundle
    always_comb begin
        w_dec = '0;
        unique case (1'b1)
            (opcode == OP_R):       w_dec = 13'b0001_0_0_0_1_0_0_0;
            (opcode == OP_I_ARITH): w_dec = 13'b0010_0_1_0_1_0_0_0;
            (opcode == OP_I_LOAD):  w_dec = 13'b0000_0_1_0_1_1_0_0;
            (opcode == OP_I_JALR):  w_dec = 13'b0000_0_1_0_1_0_0_1;
            (opcode == OP_S):       w_dec = 13'b0000_0_1_1_0_0_0_0;
            (opcode == OP_B):       w_dec = 13'b0011_0_0_0_0_0_1_0;
            (opcode == OP_LUI):     w_dec = 13'b0100_0_1_0_1_0_0_0;
            (opcode == OP_AUIPC):   w_dec = 13'b0000_1_1_0_1_0_0_0;
            (opcode == OP_JAL):     w_dec = 13'b0000_1_1_0_1_0_0_1;
            default:                w_dec = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bundle <= '0;
        end else begin
            r_bundle <= w_dec;
        end
    end

    assign {aluOp, exec_a, exec_b, mem_w, reg_w, mem2reg, bra, jmp} = r_bundle;

endmodule

// File: tb/tb_rv_controller.sv
// Scoreboard bench for rv_controller: table-driven reference model,
// directed sweeps, random opcodes and mid-cycle asynchronous reset.
module tb_rv_controller;

    logic       clk;
    logic       rst_n;
    logic [6:0] opcode;
    logic [3:0] aluOp;
    logic       exec_a;
    logic       exec_b;
    logic       mem_w;
    logic       reg_w;
    logic       mem2reg;
    logic       bra;
    logic       jmp;

    rv_controller dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .opcode  (opcode),
        .aluOp   (aluOp),
        .exec_a  (exec_a),
        .exec_b  (exec_b),
        .mem_w   (mem_w),
        .reg_w   (reg_w),
        .mem2reg (mem2reg),
        .bra     (bra),
        .jmp     (jmp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests;
    int fails;

    logic [12:0] ref_tbl [128];
    logic [6:0]  legal   [11];
    logic [12:0] exp_q   [$];
    logic [12:0] last_exp;
    logic        last_vld;

    wire [12:0] w_bundle = {aluOp, exec_a, exec_b, mem_w, reg_w, mem2reg, bra, jmp};

    task automatic chk(input string name, input logic [12:0] act, input logic [12:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic drive(input logic [6:0] op);
        @(posedge clk);
        #3;
        opcode = op;
        exp_q.push_back(ref_tbl[op]);
    endtask

    // Reference: a flat lookup of the decode table, zero everywhere else
    initial begin
        for (int i = 0; i < 128; i++) ref_tbl[i] = '0;
        ref_tbl[7'b0110011] = {4'd1, 7'b0001000};
        ref_tbl[7'b0010011] = {4'd2, 7'b0101000};
        ref_tbl[7'b0000011] = {4'd0, 7'b0101100};
        ref_tbl[7'b1100111] = {4'd0, 7'b0101001};
        ref_tbl[7'b0100011] = {4'd0, 7'b0110000};
        ref_tbl[7'b1100011] = {4'd3, 7'b0000010};
        ref_tbl[7'b0110111] = {4'd4, 7'b0101000};
        ref_tbl[7'b0010111] = {4'd0, 7'b1101000};
        ref_tbl[7'b1101111] = {4'd0, 7'b1101001};
        legal = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111,
                  7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111,
                  7'b1101111, 7'b1110011, 7'b0001111};
    end

    // Monitor: after each edge the output must be the oldest pending entry
    always @(posedge clk) begin
        #1;
        if (rst_n && exp_q.size() > 0) begin
            last_exp = exp_q.pop_front();
            last_vld = 1'b1;
            chk("bundle", w_bundle, last_exp);
            chk("inv_memw_regw", {12'd0, mem_w & reg_w}, 13'd0);
            chk("inv_bra_jmp", {12'd0, bra & jmp}, 13'd0);
            chk("inv_m2r_regw", {12'd0, mem2reg & ~reg_w}, 13'd0);
        end
    end

    // Output must hold between edges even though opcode has moved on
    always @(negedge clk) begin
        if (rst_n && last_vld) chk("hold", w_bundle, last_exp);
    end

    initial begin
        tests    = 0;
        fails    = 0;
        last_vld = 1'b0;
        last_exp = '0;
        rst_n    = 1'b0;
        opcode   = 7'b0110011;

        repeat (2) @(posedge clk);
        #1 chk("reset_hold", w_bundle, 13'd0);
        @(negedge clk);
        chk("reset_hold2", w_bundle, 13'd0);

        @(posedge clk);
        #3;
        rst_n  = 1'b1;
        opcode = 7'b0110011;
        exp_q.push_back(ref_tbl[7'b0110011]);

        for (int i = 0; i < 11; i++) drive(legal[i]);
        drive(7'b0100011);
        drive(7'b1100011);
        drive(7'b0000000);
        drive(7'b1111111);
        drive(7'b0110010);
        drive(7'b1110011);
        drive(7'b0001111);
        drive(7'b0000011);
        drive(7'b1101111);

        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 1) == 0) drive(legal[$urandom_range(0, 10)]);
            else drive(7'($urandom_range(0, 127)));
        end

        drive(7'b0110011);
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clk);
            #3;
        end
        chk("queue_drained", 13'(exp_q.size()), 13'd0);

        last_vld = 1'b0;
        #1;
        chk("pre_reset_r", w_bundle, ref_tbl[7'b0110011]);
        rst_n = 1'b0;
        #1 chk("async_reset", w_bundle, 13'd0);
        @(posedge clk);
        #1 chk("reset_low_edge", w_bundle, 13'd0);
        @(negedge clk);
        chk("reset_low_neg", w_bundle, 13'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
